// File: rtl/steering_ctrl.sv
// -----------------------------------------------------------------------------
// steering_ctrl
//
// Line-following steering controller. A bank of N raw line sensors is
// debounced, the stable vector is classified into left / right / forward /
// lost, and a five-state Moore FSM turns that class into motor commands.
// Turns are held for a minimum number of cycles so the robot does not
// oscillate. A lost line is searched for a bounded time, steering towards
// the side where the line was last seen, before the controller gives up
// and halts.
//
// Ports
//   clock   in   1  rising-edge clock for every flop
//   reset   in   1  asynchronous, active-low; clears all state immediately
//   enable  in   1  1 = steering active, 0 = forced HALT on the next edge
//   s       in   N  raw sensors: bits above the centre index are the left
//                   group, bits below it are the right group
//   left    out  1  steer left
//   right   out  1  steer right
//   walk    out  1  drive forward
//   lost    out  1  line lost, searching
//   state   out  3  FSM state code (HALT=0 FWD=1 TURN_L=2 TURN_R=3 LOST=4)
//
// There is no handshake on this block: s is sampled on every rising edge
// and the outputs are pure decodes of registered state, so they change
// only just after a rising edge (or immediately on reset).
// -----------------------------------------------------------------------------
module steering_ctrl #(
  parameter int N        = 5,   // sensor count, odd, 3..15
  parameter int DEB      = 3,   // debounce length in cycles, 1..15
  parameter int HOLD     = 4,   // minimum cycles in a turn state, 1..255
  parameter int LOST_MAX = 16   // cycles in LOST before HALT, 1..255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] s,
  output logic         left,
  output logic         right,
  output logic         walk,
  output logic         lost,
  output logic [2:0]   state
);

  localparam int C = (N - 1) / 2;

  localparam logic [3:0] DEB_C  = 4'(DEB);
  localparam logic [7:0] HOLD_C = 8'(HOLD);
  localparam logic [7:0] LOST_C = 8'(LOST_MAX);

  // Direction the line was last seen on; drives the LOST search direction.
  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_LOST   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [N-1:0] cand_q, cand_d;     // last raw sample seen
  logic [3:0]   cnt_q, cnt_d;       // cycles cand has been stable, sat. at DEB
  logic [N-1:0] d_q, d_d;           // debounced sensor vector
  state_e       state_q, state_d;
  logic [7:0]   hc_q, hc_d;         // cycles spent in the current turn
  logic [7:0]   lc_q, lc_d;         // cycles spent in LOST
  logic         last_dir_q, last_dir_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand_q     <= '0;
      cnt_q      <= '0;
      d_q        <= '0;
      state_q    <= ST_HALT;
      hc_q       <= '0;
      lc_q       <= '0;
      last_dir_q <= DIR_L;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      state_q    <= state_d;
      hc_q       <= hc_d;
      lc_q       <= lc_d;
      last_dir_q <= last_dir_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // A new raw value restarts the stability count at 1. d takes the candidate
  // on the edge where the count reaches DEB; while the count sits saturated
  // d simply reloads the same value, so it never moves on a short glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    if (s != cand_q) begin
      cand_d = s;
      cnt_d  = 4'd1;
    end else if (cnt_q < DEB_C) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (cnt_d == DEB_C) begin
      d_d = cand_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Classification of the debounced vector
  // The centre bit only matters in that it makes d non-zero; a lone centre
  // bit, or balanced side groups, means drive straight on.
  // ---------------------------------------------------------------------------
  logic [3:0] pop_l, pop_r;
  state_e     cls_state;

  always_comb begin
    pop_l = '0;
    pop_r = '0;
    for (int i = 0; i < N; i++) begin
      if (i > C && d_q[i]) pop_l = pop_l + 4'd1;
      if (i < C && d_q[i]) pop_r = pop_r + 4'd1;
    end
  end

  always_comb begin
    cls_state = ST_FWD;
    if (d_q == '0) begin
      cls_state = ST_LOST;
    end else if (pop_l > pop_r) begin
      cls_state = ST_TURN_L;
    end else if (pop_r > pop_l) begin
      cls_state = ST_TURN_R;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (d_q != '0) state_d = cls_state;
        end
        ST_FWD: begin
          state_d = cls_state;
        end
        ST_TURN_L, ST_TURN_R: begin
          // Losing the line cuts a turn short; any other change waits for
          // the hold time so a turn is never abandoned after one cycle.
          if (cls_state == ST_LOST) begin
            state_d = ST_LOST;
          end else if (hc_q >= HOLD_C) begin
            state_d = cls_state;
          end
        end
        ST_LOST: begin
          if (d_q != '0) begin
            state_d = cls_state;
          end else if (lc_q >= LOST_C) begin
            state_d = ST_HALT;
          end
        end
        default: state_d = ST_HALT;  // unused codes recover to HALT
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counters and last direction, derived from the chosen next state.
  // Counters are zero outside their own states, so leaving a state (including
  // via enable=0) always discards its count. Changing from one turn to the
  // other counts as an entry and restarts the hold.
  // ---------------------------------------------------------------------------
  logic turn_next;
  logic entering;

  always_comb begin
    hc_d       = '0;
    lc_d       = '0;
    last_dir_d = last_dir_q;
    turn_next  = (state_d == ST_TURN_L) || (state_d == ST_TURN_R);
    entering   = (state_d != state_q);

    if (turn_next) begin
      if (entering) begin
        hc_d = 8'd1;
      end else if (hc_q < HOLD_C) begin
        hc_d = hc_q + 8'd1;
      end else begin
        hc_d = hc_q;
      end
    end

    if (entering && state_d == ST_TURN_L) last_dir_d = DIR_L;
    if (entering && state_d == ST_TURN_R) last_dir_d = DIR_R;

    if (state_d == ST_LOST) begin
      if (entering) begin
        lc_d = 8'd1;
      end else begin
        // Staying in LOST implies lc_q < LOST_MAX, so this cannot wrap.
        lc_d = lc_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    left  = 1'b0;
    right = 1'b0;
    walk  = 1'b0;
    lost  = 1'b0;
    case (state_q)
      ST_FWD:    walk  = 1'b1;
      ST_TURN_L: left  = 1'b1;
      ST_TURN_R: right = 1'b1;
      ST_LOST: begin
        lost = 1'b1;
        if (last_dir_q == DIR_L) left  = 1'b1;
        else                     right = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_steering_ctrl.sv
// -----------------------------------------------------------------------------
// tb_steering_ctrl
//
// Scenario bench for steering_ctrl with N=5, DEB=3, HOLD=4, LOST_MAX=16.
// Each scenario pushes the expected observation vector
// {state[2:0], lost, walk, right, left} when it drives a cycle of stimulus,
// and pops/compares it 1 ns after the rising edge that consumes that
// stimulus. Expected vectors are worked out from the required timing:
// a new sensor value first sampled at edge k=0 moves d at k=2 and the
// state/outputs at k=3.
// -----------------------------------------------------------------------------
module tb_steering_ctrl;

  localparam int N        = 5;
  localparam int DEB      = 3;
  localparam int HOLD     = 4;
  localparam int LOST_MAX = 16;

  // Expected observation encodings {state, lost, walk, right, left}
  localparam logic [6:0] O_HALT   = 7'b000_0000;
  localparam logic [6:0] O_FWD    = 7'b001_0100;
  localparam logic [6:0] O_TL     = 7'b010_0001;
  localparam logic [6:0] O_TR     = 7'b011_0010;
  localparam logic [6:0] O_LOST_L = 7'b100_1001;
  localparam logic [6:0] O_LOST_R = 7'b100_1010;

  localparam logic [4:0] S_ZERO = 5'b00000;
  localparam logic [4:0] S_CTR  = 5'b00100;
  localparam logic [4:0] S_LEFT = 5'b11000;
  localparam logic [4:0] S_RGHT = 5'b00011;
  localparam logic [4:0] S_TIE  = 5'b10001;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] s;
  logic         left, right, walk, lost;
  logic [2:0]   state;

  always #5 clock = ~clock;

  steering_ctrl #(
    .N(N), .DEB(DEB), .HOLD(HOLD), .LOST_MAX(LOST_MAX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .s     (s),
    .left  (left),
    .right (right),
    .walk  (walk),
    .lost  (lost),
    .state (state)
  );

  wire [6:0] obs = {state, lost, walk, right, left};

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [6:0] exp_q[$];
  logic [6:0] got, want, e;
  int         n_vec = 0;
  int         n_mis = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [N-1:0] sv, input logic en);
    s      = sv;
    enable = en;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b0;
    s      = S_ZERO;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(O_HALT);
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL reset_hold got=%b want=%b", got, want);
    end
    #2;
    reset = 1'b1;  // released between edges
    for (int k = 0; k < 4; k++) begin
      drive(S_ZERO, 1'b1);
      exp_q.push_back(O_HALT);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL reset_idle k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // HALT -> FWD on a centred line, exactly DEB edges after first sample.
  task automatic test_fwd();
    for (int k = 0; k < 6; k++) begin
      drive(S_CTR, 1'b1);
      exp_q.push_back((k < DEB) ? O_HALT : O_FWD);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL fwd_latency k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // Glitches of 1 and DEB-1 cycles in FWD must not disturb anything.
  task automatic test_glitch();
    logic [N-1:0] sv;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)                sv = S_LEFT;
      else if (k == 5 || k == 6) sv = S_RGHT;
      else                       sv = S_CTR;
      drive(sv, 1'b1);
      exp_q.push_back(O_FWD);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // Left turn held for HOLD cycles although the line re-centres early.
  task automatic test_turn_hold();
    for (int k = 0; k < 10; k++) begin
      drive((k < 3) ? S_LEFT : S_CTR, 1'b1);
      if (k < 3)      e = O_FWD;
      else if (k < 7) e = O_TL;
      else            e = O_FWD;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL turn_hold k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // From TURN_R, line lost: LOST searching right for LOST_MAX cycles, HALT.
  task automatic test_lost_timeout();
    for (int k = 0; k < 31; k++) begin
      drive((k < 8) ? S_RGHT : S_ZERO, 1'b1);
      if (k < 3)                  e = O_FWD;
      else if (k < 11)            e = O_TR;
      else if (k < 11 + LOST_MAX) e = O_LOST_R;
      else                        e = O_HALT;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL lost_timeout k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // Balanced side groups go forward; enable=0 overrides a non-zero d.
  task automatic test_tie_enable();
    for (int k = 0; k < 9; k++) begin
      drive(S_TIE, !(k == 6 || k == 7));
      if (k < 3)      e = O_HALT;
      else if (k < 6) e = O_FWD;
      else if (k < 8) e = O_HALT;
      else            e = O_FWD;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL tie_enable k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // Lost while turning left searches left; enable=0 in LOST halts next edge.
  task automatic test_enable_drop_lost();
    for (int k = 0; k < 14; k++) begin
      drive((k < 5) ? S_LEFT : S_ZERO, !(k == 10 || k == 11));
      if (k < 3)       e = O_FWD;
      else if (k < 8)  e = O_TL;
      else if (k < 10) e = O_LOST_L;
      else             e = O_HALT;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL enable_drop_lost k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // Async reset mid-turn clears outputs at once and leaves no residual hold.
  task automatic test_reset_mid_turn();
    for (int k = 0; k < 5; k++) begin
      drive(S_LEFT, 1'b1);
      exp_q.push_back((k < 3) ? O_HALT : O_TL);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL pre_reset_turn k=%0d got=%b want=%b", k, got, want);
      end
    end
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back(O_HALT);
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL async_reset got=%b want=%b", got, want);
    end
    tick();
    exp_q.push_back(O_HALT);
    got = obs; want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL reset_held got=%b want=%b", got, want);
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive((k < 3) ? S_LEFT : S_CTR, 1'b1);
      if (k < 3)      e = O_HALT;
      else if (k < 7) e = O_TL;
      else            e = O_FWD;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL post_reset_turn k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // Line found again while LOST returns to the classified state.
  task automatic test_lost_recover();
    for (int k = 0; k < 10; k++) begin
      drive((k < 5) ? S_ZERO : S_CTR, 1'b1);
      if (k < 3)      e = O_FWD;
      else if (k < 8) e = O_LOST_L;
      else            e = O_FWD;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL lost_recover k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // TURN_L -> TURN_R restarts the hold and switches the search side to R.
  task automatic test_back_to_back();
    logic [N-1:0] sv;
    for (int k = 0; k < 17; k++) begin
      if (k < 3)       sv = S_LEFT;
      else if (k < 6)  sv = S_RGHT;
      else if (k < 12) sv = S_CTR;
      else             sv = S_ZERO;
      drive(sv, 1'b1);
      if (k < 3)       e = O_FWD;
      else if (k < 7)  e = O_TL;
      else if (k < 11) e = O_TR;
      else if (k < 15) e = O_FWD;
      else             e = O_LOST_R;
      exp_q.push_back(e);
      tick();
      got = obs; want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL back_to_back k=%0d got=%b want=%b", k, got, want);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_fwd();
    test_glitch();
    test_turn_hold();
    test_lost_timeout();
    test_tie_enable();
    test_enable_drop_lost();
    test_reset_mid_turn();
    test_lost_recover();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
